// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module   : debounce_filter
// Purpose  : Multi-channel switch debouncer: synchroniser, shared tick divider,
//            per-channel stable-sample counters with rise/fall pulses.
// Revision : 1.0
// ============================================================================
module debounce_filter #(
   parameter int   CLK_CNT_WIDTH = 24,
   parameter int   SW_WIDTH      = 4,
   parameter int   STABLE_CNT    = 4,
   parameter int   SYNC_STAGES   = 2,
   parameter logic INIT_LEVEL    = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CLK_CNT_WIDTH-1:0] div_i,
   input  logic                     en_i,
   input  logic [SW_WIDTH-1:0]      sw_in_i,
   output logic [SW_WIDTH-1:0]      sw_out_o,
   output logic [SW_WIDTH-1:0]      rise_o,
   output logic [SW_WIDTH-1:0]      fall_o,
   output logic                     tick_out_o
);

   localparam int                  C_CTR_W    = $clog2(STABLE_CNT + 1);
   localparam logic [C_CTR_W-1:0]  C_CTR_LAST = C_CTR_W'(STABLE_CNT - 1);
   localparam logic [SW_WIDTH-1:0] C_INIT_VEC = {SW_WIDTH{INIT_LEVEL}};

   // ------------------------------------------------------------------
   // Input synchronisers: run every clk regardless of en_i or tick.
   // ------------------------------------------------------------------
   logic [SW_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [SW_WIDTH-1:0] sync_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= C_INIT_VEC;
         end
      end else begin
         sync_q[0] <= sw_in_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Tick divider. The >= compare makes a lowered div tick on the next
   // edge instead of waiting for the counter to wrap.
   // ------------------------------------------------------------------
   logic [CLK_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                     tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (!en_i) begin
         cnt_d = '0;
      end else if (cnt_q >= div_i) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end else begin
         cnt_d = cnt_q + CLK_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_out_o = tick_q;

   // ------------------------------------------------------------------
   // Per-channel stable counters and debounced outputs.
   // ------------------------------------------------------------------
   generate
      for (genvar i = 0; i < SW_WIDTH; i++) begin : g_chan
         logic [C_CTR_W-1:0] ctr_q, ctr_d;
         logic               out_q, out_d;
         logic               rise_q, rise_d;
         logic               fall_q, fall_d;

         always_comb begin
            ctr_d  = ctr_q;
            out_d  = out_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (tick_q && en_i) begin
               if (sync_last[i] == out_q) begin
                  ctr_d = '0;
               end else if (ctr_q == C_CTR_LAST) begin
                  ctr_d  = '0;
                  out_d  = sync_last[i];
                  rise_d = sync_last[i];
                  fall_d = ~sync_last[i];
               end else begin
                  ctr_d = ctr_q + C_CTR_W'(1);
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ctr_q  <= '0;
               out_q  <= INIT_LEVEL;
               rise_q <= 1'b0;
               fall_q <= 1'b0;
            end else begin
               ctr_q  <= ctr_d;
               out_q  <= out_d;
               rise_q <= rise_d;
               fall_q <= fall_d;
            end
         end

         assign sw_out_o[i] = out_q;
         assign rise_o[i]   = rise_q;
         assign fall_o[i]   = fall_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_filter
// Purpose  : Scoreboard bench for debounce_filter with a sample-history model.
// Revision : 1.1
// ============================================================================
module tb_debounce_filter;

    localparam int CW = 24;
    localparam int SW = 4;
    localparam int SC = 4;
    localparam int SS = 2;
    localparam int EW = 3*SW + 1;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] div;
    logic          en;
    logic [SW-1:0] sw_in;
    logic [SW-1:0] sw_out;
    logic [SW-1:0] rise;
    logic [SW-1:0] fall;
    logic          tick_out;

    debounce_filter #(
        .CLK_CNT_WIDTH (CW),
        .SW_WIDTH      (SW),
        .STABLE_CNT    (SC),
        .SYNC_STAGES   (SS),
        .INIT_LEVEL    (1'b0)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_i      (div),
        .en_i       (en),
        .sw_in_i    (sw_in),
        .sw_out_o   (sw_out),
        .rise_o     (rise),
        .fall_o     (fall),
        .tick_out_o (tick_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Reference model: sw_in history gives the synchronised bit, a list of
    // the most recent tick samples per channel decides when a level flips.
    // ------------------------------------------------------------------
    logic [SW-1:0] m_out, m_rise, m_fall;
    logic          m_tick;
    int            m_elapsed;
    logic [SW-1:0] m_hist [SS];
    logic [SC-1:0] m_samp [SW];
    int            m_nsince [SW];
    logic [EW-1:0] exp_q [$];

    task automatic model_reset();
        m_out = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0; m_elapsed = 0;
        for (int s = 0; s < SS; s++) m_hist[s] = '0;
        for (int c = 0; c < SW; c++) begin
            m_samp[c] = '0;
            m_nsince[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [SW-1:0] seen;
        seen   = m_hist[SS-1];
        m_rise = '0;
        m_fall = '0;
        if (m_tick && en) begin
            for (int c = 0; c < SW; c++) begin
                m_samp[c] = {m_samp[c][SC-2:0], seen[c]};
                m_nsince[c]++;
                if (m_nsince[c] >= SC && m_samp[c] == {SC{~m_out[c]}}) begin
                    m_out[c]    = seen[c];
                    m_rise[c]   = seen[c];
                    m_fall[c]   = ~seen[c];
                    m_nsince[c] = 0;
                    m_samp[c]   = '0;
                end
            end
        end
        if (!en) begin
            m_elapsed = 0;
            m_tick    = 1'b0;
        end else if (m_elapsed >= int'(div)) begin
            m_elapsed = 0;
            m_tick    = 1'b1;
        end else begin
            m_elapsed++;
            m_tick = 1'b0;
        end
        for (int s = SS-1; s > 0; s--) m_hist[s] = m_hist[s-1];
        m_hist[0] = sw_in;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            exp_q.push_back({m_out, m_rise, m_fall, m_tick});
        end
    end

    // ------------------------------------------------------------------
    // Monitor: one comparison per clk on the falling edge.
    // ------------------------------------------------------------------
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        bit            have;
        forever begin
            @(negedge clk);
            have = 1'b0;
            e    = '0;
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                have = 1'b1;
            end
            if (!rst_n) begin
                e    = '0;
                have = 1'b1;
            end
            if (have) begin
                n_checks++;
                a = {sw_out, rise, fall, tick_out};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t actual sw_out=%h rise=%h fall=%h tick=%b required sw_out=%h rise=%h fall=%h tick=%b",
                             $time, a[3*SW:2*SW+1], a[2*SW:SW+1], a[SW:1], a[0],
                             e[3*SW:2*SW+1], e[2*SW:SW+1], e[SW:1], e[0]);
                end
            end
        end
    end

    task automatic check_reset();
        n_checks++;
        if (sw_out !== '0 || rise !== '0 || fall !== '0 || tick_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state t=%0t sw_out=%h rise=%h fall=%h tick=%b",
                     $time, sw_out, rise, fall, tick_out);
        end
    endtask

    initial begin
        bit seen_rise;
        seen_rise = 1'b0;
        @(posedge rst_n);
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (sw_out[0] === 1'b1) begin
                seen_rise = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen_rise) begin
            n_fail++;
            $display("FAIL timeout t=%0t sw_out[0] did not rise within 60 clks after clean step", $time);
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus: directed scenarios followed by randomised bouncing.
    // ------------------------------------------------------------------
    initial begin
        logic [SW-1:0] target;
        rst_n = 1'b0;
        en    = 1'b0;
        div   = 24'd3;
        sw_in = 4'hF;
        step(2);
        check_reset();
        step(2);
        check_reset();
        step(2);
        check_reset();
        sw_in = 4'h0;
        step(3);
        rst_n = 1'b1;
        en    = 1'b1;

        // clean step on channel 0
        sw_in[0] = 1'b1;
        step(30);

        // bounce on channel 1: 3 ticks high, 1 low, 3 high, then held
        sw_in[1] = 1'b1; step(12);
        sw_in[1] = 1'b0; step(4);
        sw_in[1] = 1'b1; step(12);
        step(20);

        // settle channel 2 high, then fall at div=0
        sw_in[2] = 1'b1; step(40);
        div = 24'd0;     step(3);
        sw_in[2] = 1'b0; step(12);

        // en gating midway through a pending change on channel 3
        div = 24'd3;
        step(4);
        sw_in[3] = 1'b1; step(10);
        en = 1'b0;       step(20);
        en = 1'b1;       step(24);

        // reset in the middle of a pending change on channel 0
        sw_in[0] = 1'b0; step(14);
        rst_n = 1'b0;    step(2);
        rst_n = 1'b1;    step(30);

        // lower div from 100 to 5 while cnt is 50
        rst_n = 1'b0;
        div   = 24'd100;
        step(1);
        rst_n = 1'b1;
        step(50);
        div = 24'd5;
        step(40);

        // randomised bouncing inputs
        target = sw_in;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) div = 24'($urandom_range(0, 4));
            if (en && $urandom_range(0, 59) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
            for (int ch = 0; ch < SW; ch++) begin
                if ($urandom_range(0, 39) == 0) target[ch] = ~target[ch];
                sw_in[ch] = target[ch] ^ ($urandom_range(0, 9) == 0);
            end
            if (c % 1000 == 500) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            step(1);
        end

        step(5);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 Parameter CLK_CNT_WIDTH, default 24, width of tick divider counter and div port.
REQ-002 Parameter SW_WIDTH, default 4, number of independent switch channels.
REQ-003 Parameter STABLE_CNT, default 4, consecutive differing tick samples required to change an output (legal range 1..255).
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser flop depth per channel (legal range 2..4).
REQ-005 Parameter INIT_LEVEL, default 0, reset value of sw_out and synchroniser flops, applied to all channels.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 div  input  CLK_CNT_WIDTH  tick period minus one, in clk cycles; may change at any time.
REQ-009 en  input  1  tick generator enable; low freezes filtering.
REQ-010 sw_in  input  SW_WIDTH  raw asynchronous switch inputs.
REQ-011 sw_out  output  SW_WIDTH  debounced levels, registered.
REQ-012 rise  output  SW_WIDTH  one-clk pulse per channel on sw_out 0->1, registered.
REQ-013 fall  output  SW_WIDTH  one-clk pulse per channel on sw_out 1->0, registered.
REQ-014 tick_out  output  1  registered sample strobe, one clk wide.

Function
REQ-015 Each sw_in bit passes through a SYNC_STAGES flop chain clocked every clk, independent of en and tick; the filters use only the last stage.
REQ-016 Divider: cnt counts up by 1 per clk while en=1; when cnt >= div, the next edge sets cnt=0 and tick_out=1; otherwise tick_out=0.
REQ-017 Tick rate: div=N gives one tick_out pulse every N+1 clks; div=0 gives tick_out high every clk while en=1.
REQ-018 Lowering div below the current cnt produces a tick on the next edge, then continues at the new period; no wrap-around to 2^CLK_CNT_WIDTH.
REQ-019 en=0: cnt forced to 0 next edge, tick_out=0, stable counters, sw_out held; rise/fall deasserted; synchronisers keep running.
REQ-020 Per-channel stable counter, width clog2(STABLE_CNT+1), evaluated only in cycles where tick_out=1.
REQ-021 On tick, if sync bit equals sw_out[i], counter[i] clears to 0.
REQ-022 On tick, if sync bit differs from sw_out[i] and counter[i] = STABLE_CNT-1, sw_out[i] takes the sync bit and counter[i] clears; else counter[i] increments.
REQ-023 STABLE_CNT=1: sw_out follows the sync bit on every tick.
REQ-024 rise[i]/fall[i] assert on the same edge that sw_out[i] changes, for exactly one clk; never both high for one channel.
REQ-025 Channels are fully independent; simultaneous changes on several channels each produce their own pulses in the same cycle.
REQ-026 Latency from a clean sw_in step: SYNC_STAGES clks plus STABLE_CNT ticks (+/- one tick period depending on phase).
REQ-027 Any single glitch shorter than STABLE_CNT consecutive tick samples leaves sw_out unchanged and produces no pulses.

Reset
REQ-028 rst_n low asynchronously sets cnt=0, tick_out=0, all stable counters=0, rise=0, fall=0, sw_out and synchroniser flops = INIT_LEVEL replicated.
REQ-029 Reset asserted mid-count discards partial counts; after release, the first tick_out occurs at the (div+1)th rising edge with en=1.
REQ-030 No rise/fall pulse is generated by reset assertion or release.

Verification
REQ-031 Reset: hold rst_n=0, drive sw_in=4'hF -> sw_out=0, rise=fall=0, tick_out=0 throughout reset.
REQ-032 Clean step: div=3, en=1, sw_in[0] 0->1 held -> tick_out every 4 clks; sw_out[0]=1 on the 4th tick after sync; rise[0] high exactly 1 clk, other channels static.
REQ-033 Bounce: div=3, sw_in[1] high for 3 ticks, low 1 tick, high 3 ticks -> sw_out[1] stays 0, no rise[1]; then held high 4 ticks -> sw_out[1]=1, rise[1] one pulse.
REQ-034 div=0: sw_in[2] 1->0 after prior settle at 1 -> fall[2] pulse and sw_out[2]=0 exactly 2+4 clks after the sw_in change (±1).
REQ-035 en gating: drop en for 20 clks after 2 of 4 required ticks -> no ticks, sw_out unchanged; after en=1, change occurs after 2 further ticks.
REQ-036 Mid-operation reset and div change: pulse rst_n after 3 ticks of a pending change -> outputs clear immediately, counting restarts; change div from 100 to 5 when cnt=50 -> tick on next edge, then every 6 clks.
